// File: rtl/line_scan_sequencer.sv
// rtl/line_scan_sequencer.sv - line scan address sequencer with registered one-hot line outputs
//
// Purpose:
//   After a start request, steps an address through every code of an ADDR_W-bit
//   space and holds each code for DWELL cycles. It drives the binary address and
//   a registered one-hot line vector for a downstream line decoder or consumer.
//   Supports single-pass (ends with a one-cycle done pulse) and continuous
//   wrap-around scanning, plus an abort via stop.
//
// Optional build macro:
//   LINE_SCAN_DIR_EN - adds input dir, latched with start; dir=1 scans downward
//                      from the top code to 0.
//
// Parameters:
//   ADDR_W  address width, 1..8; the block drives 2^ADDR_W lines
//   DWELL   cycles each address is held, >= 1
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   start       scan request, sampled only when idle
//   stop        abort request, sampled only while scanning
//   cont        scan mode, latched with start: 1 continuous, 0 single pass
//   dir         (LINE_SCAN_DIR_EN only) scan direction, latched with start
//   busy        high while scanning
//   addr        current address code (0 when not scanning)
//   addr_valid  high when addr and lines are meaningful
//   lines       one-hot decode of addr while valid, else all zero
//   done        one-cycle pulse after a completed single pass

module line_scan_sequencer #(
  parameter int ADDR_W = 2,
  parameter int DWELL  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cont,
`ifdef LINE_SCAN_DIR_EN
  input  logic                     dir,
`endif
  output logic                     busy,
  output logic [ADDR_W-1:0]        addr,
  output logic                     addr_valid,
  output logic [(1<<ADDR_W)-1:0]   lines,
  output logic                     done
);

  localparam int NLINES = 1 << ADDR_W;
  localparam int DW_W   = $clog2(DWELL) + 1;

  localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = '0;
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [NLINES-1:0]   lines_q, lines_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic                cont_q,  cont_d;

  // Direction: the request-time value picks the first code, the latched value
  // steers stepping for the rest of the scan.
  logic                desc_req;
  logic                desc_cur;
`ifdef LINE_SCAN_DIR_EN
  logic                dir_q, dir_d;
  assign desc_req = dir;
  assign desc_cur = dir_q;
`else
  assign desc_req = 1'b0;
  assign desc_cur = 1'b0;
`endif

  logic [ADDR_W-1:0]   first_addr;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   step_addr;
  logic                dwell_expired;

  assign first_addr    = desc_req ? ADDR_MAX  : ADDR_ZERO;
  assign last_addr     = desc_cur ? ADDR_ZERO : ADDR_MAX;
  // Stepping modulo 2^ADDR_W makes the continuous-mode wrap fall out of the
  // same adder: max+1 -> 0 ascending, 0-1 -> max descending.
  assign step_addr     = desc_cur ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
  assign dwell_expired = (dwell_q == DWELL_LAST);

  function automatic logic [NLINES-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NLINES-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lines_q <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
`ifdef LINE_SCAN_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lines_q <= lines_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
`ifdef LINE_SCAN_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lines_d = lines_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
`ifdef LINE_SCAN_DIR_EN
    dir_d   = dir_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          addr_d  = first_addr;
          lines_d = onehot(first_addr);
          dwell_d = '0;
          cont_d  = cont;
`ifdef LINE_SCAN_DIR_EN
          dir_d   = dir;
`endif
        end
      end

      S_SCAN: begin
        if (stop) begin
          // Abort wins over dwell expiry: no advance, no done pulse.
          state_d = S_IDLE;
          addr_d  = '0;
          lines_d = '0;
          dwell_d = '0;
        end else if (dwell_expired) begin
          dwell_d = '0;
          if (addr_q == last_addr && !cont_q) begin
            state_d = S_DONE;
            addr_d  = '0;
            lines_d = '0;
          end else begin
            addr_d  = step_addr;
            lines_d = onehot(step_addr);
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end

      S_DONE: begin
        // Single fixed cycle; start is not honoured until back in IDLE.
        state_d = S_IDLE;
        addr_d  = '0;
        lines_d = '0;
        dwell_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        lines_d = '0;
        dwell_d = '0;
      end
    endcase
  end

  assign busy       = (state_q == S_SCAN);
  assign addr_valid = (state_q == S_SCAN);
  assign done       = (state_q == S_DONE);
  assign addr       = addr_q;
  assign lines      = lines_q;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// tb/tb_line_scan_sequencer.sv - self-checking bench for line_scan_sequencer

module tb_line_scan_sequencer;

  localparam int ADDR_W = 2;
  localparam int DWELL  = 4;
  localparam int NL     = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              cont;
  logic              dir_s;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic [NL-1:0]     lines;
  logic              done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  line_scan_sequencer #(.ADDR_W(ADDR_W), .DWELL(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
`ifdef LINE_SCAN_DIR_EN
    .dir        (dir_s),
`endif
    .busy       (busy),
    .addr       (addr),
    .addr_valid (addr_valid),
    .lines      (lines),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a scan is "k cycles since the first valid cycle";
  // the address is simply floor(k/DWELL) modulo the number of lines.
  bit m_active = 0;
  bit m_done   = 0;
  bit m_cont   = 0;
  bit m_dir    = 0;
  int m_k      = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active <= 0;
      m_done   <= 0;
      m_k      <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_active) begin
      if (stop) begin
        m_active <= 0;
      end else if (!m_cont && (m_k + 1 == NL * DWELL)) begin
        m_active <= 0;
        m_done   <= 1;
      end else begin
        m_k <= m_k + 1;
      end
    end else if (start) begin
      m_active <= 1;
      m_k      <= 0;
      m_cont   <= cont;
`ifdef LINE_SCAN_DIR_EN
      m_dir    <= dir_s;
`else
      m_dir    <= 0;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      logic [NL-1:0] exp_lines;
      idx = (m_k / DWELL) % NL;
      if (m_dir) idx = NL - 1 - idx;
      if (!m_active) idx = 0;
      exp_lines = m_active ? (NL'(1) << idx) : '0;
      chk("model.busy",       32'(busy),       32'(m_active));
      chk("model.addr_valid", 32'(addr_valid), 32'(m_active));
      chk("model.addr",       32'(addr),       32'(idx));
      chk("model.lines",      32'(lines),      32'(exp_lines));
      chk("model.done",       32'(done),       32'(m_done));
    end
  end

  task automatic pin(input string tag, input int a, input int l, input int v,
                     input int b, input int d);
    chk({tag, ".addr"},       32'(addr),       a);
    chk({tag, ".lines"},      32'(lines),      l);
    chk({tag, ".addr_valid"}, 32'(addr_valid), v);
    chk({tag, ".busy"},       32'(busy),       b);
    chk({tag, ".done"},       32'(done),       d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; stop = 0; cont = 0; dir_s = 0;
    @(negedge clk);
    chk_en = 1;
    pin("reset", 0, 0, 0, 0, 0);
    rst_n = 1;
  endtask

  task automatic drive(input int s, input int c);
    rst_n = 1; start = 0; stop = 0; cont = 0; dir_s = 0;
    case (s)
      0: start = (c == 0);
      1: begin start = (c == 0); cont = (c == 0); stop = (c == 20); end
      2: begin start = (c == 0); stop = (c == 8); end
      3: start = (c == 0) || (c == 6) || (c >= 15 && c <= 19);
      4: begin start = (c == 0) || (c == 12); rst_n = !(c == 10); end
      default: ;
    endcase
  endtask

  task automatic lits(input int s, input int c);
    string t;
    t = $sformatf("s%0d.c%0d", s, c);
    case (s)
      0: case (c)
           1:  pin(t, 0, 1, 1, 1, 0);
           4:  pin(t, 0, 1, 1, 1, 0);
           5:  pin(t, 1, 2, 1, 1, 0);
           9:  pin(t, 2, 4, 1, 1, 0);
           13: pin(t, 3, 8, 1, 1, 0);
           16: pin(t, 3, 8, 1, 1, 0);
           17: pin(t, 0, 0, 0, 0, 1);
           18: pin(t, 0, 0, 0, 0, 0);
           default: ;
         endcase
      1: case (c)
           16: pin(t, 3, 8, 1, 1, 0);
           17: pin(t, 0, 1, 1, 1, 0);
           20: pin(t, 0, 1, 1, 1, 0);
           21: pin(t, 0, 0, 0, 0, 0);
           default: ;
         endcase
      2: case (c)
           8:  pin(t, 1, 2, 1, 1, 0);
           9:  pin(t, 0, 0, 0, 0, 0);
           10: pin(t, 0, 0, 0, 0, 0);
           default: ;
         endcase
      3: case (c)
           7:  pin(t, 1, 2, 1, 1, 0);
           9:  pin(t, 2, 4, 1, 1, 0);
           17: pin(t, 0, 0, 0, 0, 1);
           18: pin(t, 0, 0, 0, 0, 0);
           19: pin(t, 0, 1, 1, 1, 0);
           default: ;
         endcase
      4: case (c)
           10: pin(t, 2, 4, 1, 1, 0);
           11: pin(t, 0, 0, 0, 0, 0);
           12: pin(t, 0, 0, 0, 0, 0);
           13: pin(t, 0, 1, 1, 1, 0);
           default: ;
         endcase
      default: ;
    endcase
  endtask

  int scen_len[5] = '{20, 23, 12, 22, 16};

  initial begin
    rst_n = 0; start = 0; stop = 0; cont = 0; dir_s = 0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 5; s++) begin
      do_reset();
      for (int c = 0; c <= scen_len[s]; c++) begin
        @(negedge clk);
        if (c > 0) lits(s, c);
        drive(s, c);
      end
    end

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      cont  = 1'($urandom_range(0, 1));
      dir_s = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_scan_sequencer.md
Name: line_scan_sequencer

Overview:
Upstream address sequencer for the line decoders. After a start request it steps an address through 0..2^ADDR_W-1, holding each code for DWELL cycles. It outputs the binary address plus a registered one-hot line vector, so a downstream n-to-2^n line decoder or a direct line consumer can be fed. It supports single-pass and continuous (wrap-around) scanning, and signals completion with a one-cycle done pulse.

Parameters:
ADDR_W, 2, address width in bits; the block drives 2^ADDR_W lines; legal range 1..8
DWELL, 4, cycles each address is held; legal range DWELL >= 1; the dwell counter is clog2(DWELL)+1 bits wide

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  scan request; sampled only in IDLE
stop  input  1  abort request; sampled only in SCAN
cont  input  1  scan mode, sampled with start: 1 = continuous wrap, 0 = single pass
busy  output  1  high while in SCAN
addr  output  ADDR_W  current address code
addr_valid  output  1  high when addr and lines are meaningful
lines  output  2^ADDR_W  registered one-hot decode of addr while valid, else all zero
done  output  1  one-cycle pulse at the end of a completed single pass

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low.
- While rst_n=0 at a rising edge, the block loads: state IDLE, addr=0, addr_valid=0, lines=0, busy=0, done=0, dwell counter=0, cont register=0.
- Reset mid-scan aborts immediately at that edge; no done pulse is produced.
- States: IDLE, SCAN, DONE.
- IDLE, start=1: on the next edge the block enters SCAN and sets addr=0, lines=1, addr_valid=1, busy=1, dwell=0, and latches cont. Latency from start to first valid output is 1 cycle.
- IDLE, start=0: all outputs remain at their reset values.
- SCAN, each cycle: the dwell counter increments.
- SCAN, dwell==DWELL-1 and addr < 2^ADDR_W-1: addr increments, dwell clears, lines shifts to the new one-hot value in the same edge.
- SCAN, dwell==DWELL-1 and addr == max, cont=1: addr wraps to 0, lines=1, dwell clears; no done pulse.
- SCAN, dwell==DWELL-1 and addr == max, cont=0: enter DONE.
- SCAN, stop=1: enter IDLE on the next edge. All outputs clear and no done pulse is produced. stop has priority over the dwell-expiry transition.
- SCAN: start is ignored. Input cont is ignored after start; the latched copy is used.
- DONE (exactly one cycle): done=1, busy=0, addr_valid=0, lines=0, addr=0. The next state is always IDLE, and start is ignored in DONE.
- Invariant: lines == (addr_valid ? 1<<addr : 0) on every cycle; lines is never multi-hot.
- Timing: each address is visible for exactly DWELL cycles. A single pass lasts 2^ADDR_W*DWELL cycles, followed by one DONE cycle.
- DWELL=1: addr advances every cycle.

Optional Feature:
LINE_SCAN_DIR_EN
- Defined: adds input port dir (1 bit), sampled and latched with start. With dir=1 the scan starts at addr=2^ADDR_W-1, decrements, ends or wraps at 0, and wraps back to max. With dir=0 behaviour is identical to the undefined case.
- Undefined: no dir port; the scan is always ascending as described above.

Test Plan:
(All with ADDR_W=2, DWELL=4, start asserted for one cycle at cycle 0.)
- Single pass, cont=0 -> addr/lines are 0/0001 for cycles 1-4, 1/0010 for 5-8, 2/0100 for 9-12, 3/1000 for 13-16. done=1 and busy=0 in cycle 17; IDLE in cycle 18.
- Continuous, cont=1 -> cycle 17 shows addr=0, lines=0001, busy=1, done never asserts; stop at cycle 20 -> cycle 21 shows all outputs 0.
- Stop and expiry coincide: stop=1 at cycle 8 (dwell expiry of addr 1) -> cycle 9 is IDLE, addr_valid=0, lines=0, done=0, and addr does not advance to 2.
- Start while busy: start pulsed at cycle 6 -> ignored; sequence identical to the single-pass case. Start held high through DONE -> new scan begins with addr=0 in cycle 19.
- Reset mid-scan: rst_n=0 at cycle 10 -> cycle 11 shows all outputs at reset values; start at cycle 12 -> addr=0 valid at cycle 13.
- DWELL=1 build -> addr 0,1,2,3 in cycles 1-4, done in cycle 5. LINE_SCAN_DIR_EN build with dir=1 -> addr 3,2,1,0 with lines 1000,0100,0010,0001.
